bp_lce_port_concentrator: RTL and testbench

- Generalised LCE network attachment for a core with num_lce_p cache engines (I$, D$, accelerators), replacing fixed two-channel wiring.
- Merges N outgoing LCE request channels onto one coherence-network request port:
  - per-channel buffering;
  - round-robin arbitration;
  - per-channel outstanding-request credits.
- Demultiplexes one incoming LCE command port to N engines by destination LCE id.
- Sits between the LCEs and the coherence NoC link.

---
 rtl/bp_top_pkg.sv | 40 ++++
 rtl/bp_lce_conc_chan.sv | 76 +++++++
 rtl/bp_lce_port_concentrator.sv | 171 +++++++++++++++++
 tb/tb_bp_lce_port_concentrator.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_top_pkg.sv
// Shared types and configuration helpers for the LCE port concentrator.
// Command header layout: dst_id occupies the low lce_id_width bits of the message.
package bp_top_pkg;

    localparam int unsigned max_lce_gp = 16;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_small_cfg   = 2'd1
    } bp_params_e;

    typedef enum logic [1:0] {
        e_conc_err_none     = 2'd0,
        e_conc_err_overflow = 2'd1,
        e_conc_err_credit   = 2'd2,
        e_conc_err_dst      = 2'd3
    } conc_err_e;

    function automatic int unsigned lce_id_width(bp_params_e cfg);
        case (cfg)
            e_bp_small_cfg: return 4;
            default:        return 5;
        endcase
    endfunction

    function automatic int unsigned lce_req_msg_width(bp_params_e cfg);
        case (cfg)
            e_bp_small_cfg: return 24;
            default:        return 32;
        endcase
    endfunction

    function automatic int unsigned lce_cmd_msg_width(bp_params_e cfg);
        case (cfg)
            e_bp_small_cfg: return 32;
            default:        return 40;
        endcase
    endfunction

endpackage

// File: rtl/bp_lce_conc_chan.sv
// One concentrator channel: request FIFO (pointer + phase bit), credit counter, eligibility.
module bp_lce_conc_chan #(
    parameter int unsigned width_p   = 32,
    parameter int unsigned els_p     = 2,
    parameter int unsigned credits_p = 8,
    localparam int unsigned ptr_width_lp = $clog2(els_p),
    localparam int unsigned cnt_width_lp = $clog2(credits_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    push,
    input  logic [width_p-1:0]      push_data,
    input  logic                    pop,
    input  logic                    credit_dec,
    output logic                    ready,
    output logic [width_p-1:0]      head,
    output logic                    eligible,
    output logic [cnt_width_lp-1:0] credit_cnt
);

    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] rd_ptr_q, wr_ptr_q;
    logic                    rd_phase_q, wr_phase_q;
    logic [cnt_width_lp-1:0] cnt_q;
    logic                    empty, full;

    // Equal pointers: phase bits tell empty from full.
    assign empty = (rd_ptr_q == wr_ptr_q) && (rd_phase_q == wr_phase_q);
    assign full  = (rd_ptr_q == wr_ptr_q) && (rd_phase_q != wr_phase_q);

    assign ready      = ~full;
    assign head       = mem_q[rd_ptr_q];
    assign eligible   = ~empty && (32'(cnt_q) < credits_p);
    assign credit_cnt = cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_phase_q <= 1'b0;
            wr_phase_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                if (wr_ptr_q == last_ptr_lp) begin
                    wr_ptr_q   <= '0;
                    wr_phase_q <= ~wr_phase_q;
                end else begin
                    wr_ptr_q <= wr_ptr_q + ptr_width_lp'(1);
                end
            end
            if (pop) begin
                if (rd_ptr_q == last_ptr_lp) begin
                    rd_ptr_q   <= '0;
                    rd_phase_q <= ~rd_phase_q;
                end else begin
                    rd_ptr_q <= rd_ptr_q + ptr_width_lp'(1);
                end
            end
            if (pop && !credit_dec) begin
                cnt_q <= cnt_q + cnt_width_lp'(1);
            end else if (credit_dec && !pop) begin
                cnt_q <= cnt_q - cnt_width_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bp_lce_port_concentrator.sv
// Merges N LCE request channels onto one network port and demuxes commands by dst id.
// Optional per-channel grant counters on stat_o when BP_LCE_CONC_STATS_EN is defined.
module bp_lce_port_concentrator
    import bp_top_pkg::*;
#(
    parameter bp_params_e  bp_params_p = e_bp_default_cfg,
    parameter int unsigned num_lce_p   = 4,
    parameter int unsigned fifo_els_p  = 2,
    parameter int unsigned credits_p   = 8,
    localparam int unsigned lce_id_width_p       = lce_id_width(bp_params_p),
    localparam int unsigned lce_req_msg_width_lp = lce_req_msg_width(bp_params_p),
    localparam int unsigned lce_cmd_msg_width_lp = lce_cmd_msg_width(bp_params_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [lce_id_width_p-1:0]                 lce_id_base_i,
    input  logic [num_lce_p*lce_req_msg_width_lp-1:0] lce_req_i,
    input  logic [num_lce_p-1:0]                      lce_req_v_i,
    output logic [num_lce_p-1:0]                      lce_req_ready_then_o,
    output logic [lce_req_msg_width_lp-1:0]           lce_req_o,
    output logic                                      lce_req_v_o,
    input  logic                                      lce_req_ready_then_i,
    input  logic                                      credit_return_v_i,
    input  logic [lce_id_width_p-1:0]                 credit_return_id_i,
    input  logic [lce_cmd_msg_width_lp-1:0]           lce_cmd_i,
    input  logic                                      lce_cmd_v_i,
    output logic                                      lce_cmd_yumi_o,
    output logic [lce_cmd_msg_width_lp-1:0]           lce_cmd_o,
    output logic [num_lce_p-1:0]                      lce_cmd_v_o,
    input  logic [num_lce_p-1:0]                      lce_cmd_yumi_i,
    output logic                                      err_o,
    output logic [num_lce_p*32-1:0]                   stat_o
);

    localparam int unsigned ptr_width_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(credits_p + 1);

    logic                                           live_q;
    logic [num_lce_p-1:0]                           chan_ready, eligible, push, pop, credit_dec;
    logic [num_lce_p-1:0][lce_req_msg_width_lp-1:0] head;
    logic [num_lce_p-1:0][cnt_width_lp-1:0]         credit_cnt;
    logic [ptr_width_lp-1:0]                        rr_ptr_q, grant_idx;
    logic                                           grant_v, send;
    logic [lce_id_width_p-1:0]                      ret_idx, cmd_idx;
    logic [num_lce_p-1:0]                           cmd_hit;
    logic                                           cmd_in_range;
    logic                                           err_overflow, err_credit, err_dst;
    logic                                           err_q;
    conc_err_e                                      err_cause_q;

    // Holds every output at 0 until the first clock edge after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) live_q <= 1'b0;
        else            live_q <= 1'b1;
    end

    assign lce_req_ready_then_o = chan_ready & {num_lce_p{live_q}};
    assign push                 = lce_req_v_i & lce_req_ready_then_o;

    for (genvar k = 0; k < num_lce_p; k++) begin : g_chan
        bp_lce_conc_chan #(
            .width_p   (lce_req_msg_width_lp),
            .els_p     (fifo_els_p),
            .credits_p (credits_p)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .push       (push[k]),
            .push_data  (lce_req_i[k*lce_req_msg_width_lp +: lce_req_msg_width_lp]),
            .pop        (pop[k]),
            .credit_dec (credit_dec[k]),
            .ready      (chan_ready[k]),
            .head       (head[k]),
            .eligible   (eligible[k]),
            .credit_cnt (credit_cnt[k])
        );
    end

    // Round-robin: first eligible channel at or after the pointer.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < num_lce_p; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= num_lce_p) cand = cand - num_lce_p;
            if (!grant_v && eligible[cand]) begin
                grant_v   = 1'b1;
                grant_idx = ptr_width_lp'(cand);
            end
        end
    end

    assign send        = live_q && grant_v && lce_req_ready_then_i;
    assign lce_req_v_o = send;
    assign lce_req_o   = send ? head[grant_idx] : '0;

    always_comb begin
        pop = '0;
        if (send) pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_q <= '0;
        end else if (send) begin
            rr_ptr_q <= (grant_idx == ptr_width_lp'(num_lce_p - 1))
                        ? '0 : grant_idx + ptr_width_lp'(1);
        end
    end

    // Ids are relative to the base, wrapping modulo 2^lce_id_width_p.
    assign ret_idx = credit_return_id_i - lce_id_base_i;
    assign cmd_idx = lce_cmd_i[lce_id_width_p-1:0] - lce_id_base_i;

    always_comb begin
        credit_dec = '0;
        cmd_hit    = '0;
        for (int unsigned k = 0; k < num_lce_p; k++) begin
            credit_dec[k] = live_q && credit_return_v_i
                            && (ret_idx == lce_id_width_p'(k)) && (credit_cnt[k] != '0);
            cmd_hit[k]    = (cmd_idx == lce_id_width_p'(k));
        end
    end

    assign cmd_in_range   = |cmd_hit;
    assign lce_cmd_o      = live_q ? lce_cmd_i : '0;
    assign lce_cmd_v_o    = (live_q && lce_cmd_v_i) ? cmd_hit : '0;
    assign lce_cmd_yumi_o = live_q && (cmd_in_range ? |(cmd_hit & lce_cmd_yumi_i) : lce_cmd_v_i);

    assign err_overflow = live_q && |(lce_req_v_i & ~lce_req_ready_then_o);
    assign err_credit   = live_q && credit_return_v_i && !(|credit_dec);
    assign err_dst      = live_q && lce_cmd_v_i && !cmd_in_range;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q       <= 1'b0;
            err_cause_q <= e_conc_err_none;
        end else if (!err_q && (err_overflow || err_credit || err_dst)) begin
            err_q <= 1'b1;
            if (err_overflow)    err_cause_q <= e_conc_err_overflow;
            else if (err_credit) err_cause_q <= e_conc_err_credit;
            else                 err_cause_q <= e_conc_err_dst;
        end
    end

    assign err_o = err_q;

    a_err_cause: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        err_q |-> (err_cause_q != e_conc_err_none));

`ifdef BP_LCE_CONC_STATS_EN
    logic [num_lce_p-1:0][31:0] stat_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_q <= '0;
        end else begin
            for (int unsigned k = 0; k < num_lce_p; k++) begin
                if (pop[k] && (stat_q[k] != 32'hFFFF_FFFF)) stat_q[k] <= stat_q[k] + 32'd1;
            end
        end
    end

    assign stat_o = stat_q;
`else
    assign stat_o = '0;
`endif

endmodule

// File: tb/tb_bp_lce_port_concentrator.sv
// Directed bench for bp_lce_port_concentrator: 4 channels, id base 8, 2-deep FIFOs, 2 credits.
module tb_bp_lce_port_concentrator;
    import bp_top_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned IdW  = lce_id_width(e_bp_default_cfg);
    localparam int unsigned ReqW = lce_req_msg_width(e_bp_default_cfg);
    localparam int unsigned CmdW = lce_cmd_msg_width(e_bp_default_cfg);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [IdW-1:0]    lce_id_base;
    logic [N*ReqW-1:0] lce_req_i;
    logic [N-1:0]      lce_req_v_i;
    logic [N-1:0]      lce_req_ready_then_o;
    logic [ReqW-1:0]   lce_req_o;
    logic              lce_req_v_o;
    logic              lce_req_ready_then_i;
    logic              credit_return_v;
    logic [IdW-1:0]    credit_return_id;
    logic [CmdW-1:0]   lce_cmd_i;
    logic              lce_cmd_v_i;
    logic              lce_cmd_yumi_o;
    logic [CmdW-1:0]   lce_cmd_o;
    logic [N-1:0]      lce_cmd_v_o;
    logic [N-1:0]      lce_cmd_yumi_i;
    logic              err_o;
    logic [N*32-1:0]   stat_o;

    int checks   = 0;
    int failures = 0;

    bp_lce_port_concentrator #(
        .bp_params_p (e_bp_default_cfg),
        .num_lce_p   (N),
        .fifo_els_p  (2),
        .credits_p   (2)
    ) dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n),
        .lce_id_base_i        (lce_id_base),
        .lce_req_i            (lce_req_i),
        .lce_req_v_i          (lce_req_v_i),
        .lce_req_ready_then_o (lce_req_ready_then_o),
        .lce_req_o            (lce_req_o),
        .lce_req_v_o          (lce_req_v_o),
        .lce_req_ready_then_i (lce_req_ready_then_i),
        .credit_return_v_i    (credit_return_v),
        .credit_return_id_i   (credit_return_id),
        .lce_cmd_i            (lce_cmd_i),
        .lce_cmd_v_i          (lce_cmd_v_i),
        .lce_cmd_yumi_o       (lce_cmd_yumi_o),
        .lce_cmd_o            (lce_cmd_o),
        .lce_cmd_v_o          (lce_cmd_v_o),
        .lce_cmd_yumi_i       (lce_cmd_yumi_i),
        .err_o                (err_o),
        .stat_o               (stat_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lce_id_base          = IdW'(8);
        lce_req_i            = '0;
        lce_req_v_i          = '0;
        lce_req_ready_then_i = 1'b1;
        credit_return_v      = 1'b0;
        credit_return_id     = '0;
        lce_cmd_i            = '0;
        lce_cmd_v_i          = 1'b0;
        lce_cmd_yumi_i       = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (lce_req_ready_then_o !== 4'b0000 || lce_req_v_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: ready=%b v=%b err=%b, required 0000/0/0",
                     lce_req_ready_then_o, lce_req_v_o, err_o);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (lce_req_ready_then_o !== 4'b1111 || lce_req_v_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b v=%b, required 1111/0",
                     lce_req_ready_then_o, lce_req_v_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) lce_req_i[k*ReqW +: ReqW] = 32'hA000_0000 + 32'(k);
        lce_req_v_i = 4'b1111;
        tick();
        lce_req_v_i = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lce_req_v_o !== 1'b1 || lce_req_o !== 32'hA000_0000 + 32'(k)) begin
                failures++;
                $display("FAIL rr_order%0d: v=%b data=%h, required 1/%h",
                         k, lce_req_v_o, lce_req_o, 32'hA000_0000 + 32'(k));
            end
            tick();
        end
        checks++;
        if (lce_req_v_o !== 1'b0) begin
            failures++;
            $display("FAIL rr_drained: v=%b, required 0", lce_req_v_o);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut.credit_cnt[k] !== 2'd1) begin
                failures++;
                $display("FAIL rr_credit%0d: cnt=%0d, required 1", k, dut.credit_cnt[k]);
            end
        end
    endtask

    task automatic test_credits();
        do_reset();
        lce_req_v_i[2] = 1'b1;
        lce_req_i[2*ReqW +: ReqW] = 32'hC200_0001;
        tick();
        lce_req_i[2*ReqW +: ReqW] = 32'hC200_0002;
        checks++;
        if (lce_req_v_o !== 1'b1 || lce_req_o !== 32'hC200_0001) begin
            failures++;
            $display("FAIL credit_first: v=%b data=%h, required 1/c2000001", lce_req_v_o, lce_req_o);
        end
        tick();
        lce_req_i[2*ReqW +: ReqW] = 32'hC200_0003;
        checks++;
        if (lce_req_v_o !== 1'b1 || lce_req_o !== 32'hC200_0002) begin
            failures++;
            $display("FAIL credit_second: v=%b data=%h, required 1/c2000002", lce_req_v_o, lce_req_o);
        end
        tick();
        lce_req_v_i = '0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (lce_req_v_o !== 1'b0) begin
                failures++;
                $display("FAIL credit_block%0d: v=%b, required 0", c, lce_req_v_o);
            end
            tick();
        end
        credit_return_v  = 1'b1;
        credit_return_id = IdW'(10);
        tick();
        credit_return_v = 1'b0;
        checks++;
        if (lce_req_v_o !== 1'b1 || lce_req_o !== 32'hC200_0003) begin
            failures++;
            $display("FAIL credit_release: v=%b data=%h, required 1/c2000003", lce_req_v_o, lce_req_o);
        end
        tick();
        checks++;
        if (lce_req_v_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL credit_after: v=%b err=%b, required 0/0", lce_req_v_o, err_o);
        end
    endtask

    task automatic test_cmd_demux();
        logic [CmdW-1:0] cmd;
        do_reset();
        cmd = '0;
        cmd[CmdW-1:IdW] = '1;
        cmd[IdW-1:0]    = IdW'(9);
        lce_cmd_i       = cmd;
        lce_cmd_v_i     = 1'b1;
        lce_cmd_yumi_i  = 4'b0000;
        #1;
        checks++;
        if (lce_cmd_v_o !== 4'b0010 || lce_cmd_yumi_o !== 1'b0 || lce_cmd_o !== cmd) begin
            failures++;
            $display("FAIL cmd_route: v=%b yumi=%b data=%h, required 0010/0/%h",
                     lce_cmd_v_o, lce_cmd_yumi_o, lce_cmd_o, cmd);
        end
        lce_cmd_yumi_i = 4'b0010;
        #1;
        checks++;
        if (lce_cmd_yumi_o !== 1'b1) begin
            failures++;
            $display("FAIL cmd_yumi_sel: yumi=%b, required 1", lce_cmd_yumi_o);
        end
        lce_cmd_yumi_i = 4'b1101;
        #1;
        checks++;
        if (lce_cmd_yumi_o !== 1'b0) begin
            failures++;
            $display("FAIL cmd_yumi_other: yumi=%b, required 0", lce_cmd_yumi_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL cmd_no_err: err=%b, required 0", err_o);
        end
        lce_cmd_yumi_i       = 4'b0000;
        lce_cmd_i[IdW-1:0]   = IdW'(12);
        #1;
        checks++;
        if (lce_cmd_v_o !== 4'b0000 || lce_cmd_yumi_o !== 1'b1) begin
            failures++;
            $display("FAIL cmd_drop: v=%b yumi=%b, required 0000/1", lce_cmd_v_o, lce_cmd_yumi_o);
        end
        tick();
        lce_cmd_v_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL cmd_err: err=%b, required 1", err_o);
        end
        // Below the base wraps to a large index and is also out of range.
        do_reset();
        lce_cmd_i[IdW-1:0] = IdW'(7);
        lce_cmd_v_i        = 1'b1;
        #1;
        checks++;
        if (lce_cmd_v_o !== 4'b0000 || lce_cmd_yumi_o !== 1'b1) begin
            failures++;
            $display("FAIL cmd_below_base: v=%b yumi=%b, required 0000/1", lce_cmd_v_o, lce_cmd_yumi_o);
        end
        tick();
        lce_cmd_v_i = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        lce_req_ready_then_i = 1'b0;
        lce_req_v_i[0]       = 1'b1;
        lce_req_i[0 +: ReqW] = 32'hB000_0001;
        tick();
        lce_req_i[0 +: ReqW] = 32'hB000_0002;
        checks++;
        if (lce_req_ready_then_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_one: ready0=%b, required 1", lce_req_ready_then_o[0]);
        end
        tick();
        lce_req_v_i = '0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (lce_req_ready_then_o[0] !== 1'b0 || lce_req_v_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: ready0=%b v=%b, required 0/0",
                         c, lce_req_ready_then_o[0], lce_req_v_o);
            end
            tick();
        end
        lce_req_ready_then_i = 1'b1;
        #1;
        checks++;
        if (lce_req_v_o !== 1'b1 || lce_req_o !== 32'hB000_0001) begin
            failures++;
            $display("FAIL bp_first: v=%b data=%h, required 1/b0000001", lce_req_v_o, lce_req_o);
        end
        tick();
        checks++;
        if (lce_req_v_o !== 1'b1 || lce_req_o !== 32'hB000_0002 || lce_req_ready_then_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_second: v=%b data=%h ready0=%b, required 1/b0000002/1",
                     lce_req_v_o, lce_req_o, lce_req_ready_then_o[0]);
        end
        tick();
        checks++;
        if (lce_req_v_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: v=%b err=%b, required 0/0", lce_req_v_o, err_o);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        lce_req_ready_then_i = 1'b0;
        lce_req_i   = {4{32'hDEAD_BEEF}};
        lce_req_v_i = 4'b0011;
        tick();
        lce_req_v_i      = '0;
        credit_return_v  = 1'b1;
        credit_return_id = IdW'(8);
        tick();
        credit_return_v = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_err_set: err=%b, required 1", err_o);
        end
        lce_cmd_i            = '0;
        lce_cmd_i[IdW-1:0]   = IdW'(9);
        lce_cmd_v_i          = 1'b1;
        lce_cmd_yumi_i       = 4'b0010;
        lce_req_ready_then_i = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (lce_req_ready_then_o !== '0 || lce_req_v_o !== 1'b0 || lce_req_o !== '0 ||
            lce_cmd_v_o !== '0 || lce_cmd_yumi_o !== 1'b0 || lce_cmd_o !== '0 ||
            err_o !== 1'b0 || stat_o !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: ready=%b v=%b req=%h cv=%b cy=%b err=%b, required all 0",
                     lce_req_ready_then_o, lce_req_v_o, lce_req_o, lce_cmd_v_o, lce_cmd_yumi_o, err_o);
        end
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (lce_req_ready_then_o !== 4'b1111 || lce_req_v_o !== 1'b0 || dut.credit_cnt[0] !== 2'd0) begin
            failures++;
            $display("FAIL mid_after: ready=%b v=%b cnt0=%0d, required 1111/0/0",
                     lce_req_ready_then_o, lce_req_v_o, dut.credit_cnt[0]);
        end
    endtask

    task automatic test_stats();
        do_reset();
        lce_req_i[ReqW +: ReqW] = 32'h5000_0001;
        for (int g = 0; g < 3; g++) begin
            lce_req_v_i[1] = 1'b1;
            tick();
            lce_req_v_i[1] = 1'b0;
            tick();
            credit_return_v  = 1'b1;
            credit_return_id = IdW'(9);
            tick();
            credit_return_v = 1'b0;
        end
`ifdef BP_LCE_CONC_STATS_EN
        checks++;
        if (stat_o[63:32] !== 32'd3 || stat_o[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL stats_ch1: stat1=%0d stat0=%0d, required 3/0", stat_o[63:32], stat_o[31:0]);
        end
`else
        checks++;
        if (stat_o !== '0) begin
            failures++;
            $display("FAIL stats_tied: stat=%h, required 0", stat_o);
        end
`endif
        checks++;
        if (err_o !== 1'b0 || dut.credit_cnt[1] !== 2'd0) begin
            failures++;
            $display("FAIL stats_credit: err=%b cnt1=%0d, required 0/0", err_o, dut.credit_cnt[1]);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credits();
        test_cmd_demux();
        test_backpressure();
        test_reset_mid_op();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
